// File: rtl/shift_tx_ctrl.sv
// rtl/shift_tx_ctrl.sv - valid/ready parallel-in, LSB-first serial-out transmitter controller.
// Optional even-parity bit appended after the data MSB when SHIFT_TX_PARITY_EN is defined.
module shift_tx_ctrl #(
  parameter int N    = 8,
  parameter int DVSR = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         s_out,
  output logic         busy,
  output logic         done_tick
);

`ifdef SHIFT_TX_PARITY_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif
  localparam int BITS = W;
  localparam int BCW  = $clog2(N + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [W-1:0]   load_word;
  logic           accept;
  logic           tick_wrap;

`ifdef SHIFT_TX_PARITY_EN
  assign load_word = {^din, din};
`else
  assign load_word = din;
`endif

  assign accept = (state_q == IDLE) && din_valid;

  generate
    if (DVSR > 1) begin : g_tick
      localparam int TW = $clog2(DVSR);
      logic [TW-1:0] tcnt_q, tcnt_d;

      assign tick_wrap = (tcnt_q == TW'(DVSR - 1));

      always_comb begin
        tcnt_d = tcnt_q;
        if (accept) begin
          tcnt_d = '0;
        end else if (state_q == SHIFT) begin
          tcnt_d = tick_wrap ? '0 : tcnt_q + TW'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) tcnt_q <= '0;
        else       tcnt_q <= tcnt_d;
      end
    end else begin : g_no_tick
      // Every SHIFT cycle ends a bit period.
      assign tick_wrap = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          sreg_d  = load_word;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_wrap) begin
          sreg_d = {1'b0, sreg_q[W-1:1]};
          bcnt_d = bcnt_q + BCW'(1);
          if (bcnt_q == BCW'(BITS - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Outputs decode registered state only, so reset forces them without waiting for an edge.
  assign din_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done_tick = (state_q == DONE);
  assign s_out     = (state_q == SHIFT) ? sreg_q[0] : 1'b1;

endmodule
